// File: rtl/bch_pkg.sv
// rtl/bch_pkg.sv - shared state encoding, BCH(15,7) defaults and clog2 for the serial BCH encoder
package bch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MSG  = 2'd1,
    ST_PAR  = 2'd2
  } bch_state_t;

  localparam int         N_DEF     = 15;
  localparam int         K_DEF     = 7;
  localparam logic [8:0] GPOLY_DEF = 9'h1D1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/bch_lfsr_rem.sv
// rtl/bch_lfsr_rem.sv - P-bit Galois remainder register; fb_en=0 turns it into a plain zero-fill shifter
module bch_lfsr_rem
  import bch_pkg::*;
#(
  parameter int           P = 8,
  parameter logic [P-1:0] G = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         din,
  input  logic         fb_en,
  output logic [P-1:0] rem
);

  logic [P-1:0] r_rem;
  logic [P-1:0] w_next;
  logic         w_fb;

  always_comb begin
    w_fb   = fb_en & (din ^ r_rem[P-1]);
    w_next = (r_rem << 1) ^ (w_fb ? G : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      r_rem <= '0;
    else if (clr) r_rem <= '0;
    else if (en)  r_rem <= w_next;
  end

  assign rem = r_rem;

endmodule

// File: rtl/bch_enc_serial.sv
// rtl/bch_enc_serial.sv - systematic bit-serial BCH encoder: K message bits then N-K parity bits, MSB first
// Optional BCH_ENC_PARITY_PORT_EN adds parity/parity_valid outputs carrying the final remainder.
module bch_enc_serial
  import bch_pkg::*;
#(
  parameter int           N     = N_DEF,
  parameter int           K     = K_DEF,
  parameter logic [N-K:0] GPOLY = GPOLY_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [K-1:0]   msg,
  input  logic           msg_valid,
  output logic           msg_ready,
  output logic           cw_bit,
  output logic           cw_valid,
  input  logic           cw_ready,
  output logic           cw_last
`ifdef BCH_ENC_PARITY_PORT_EN
  ,
  output logic [N-K-1:0] parity,
  output logic           parity_valid
`endif
);

  localparam int           P     = N - K;
  localparam int           MAXKP = (K > P) ? K : P;
  localparam int           CW    = (MAXKP > 1) ? clog2(MAXKP) : 1;
  localparam logic [P-1:0] W_G   = GPOLY[P-1:0];

  bch_state_t    r_state;
  bch_state_t    w_state_next;
  logic [K-1:0]  r_sr;
  logic [CW-1:0] r_cnt;
  logic [P-1:0]  w_rem;
  logic          w_accept;
  logic          w_beat;
  logic          w_last;

  always_comb begin
    w_state_next = r_state;
    msg_ready    = 1'b0;
    cw_valid     = 1'b0;
    cw_bit       = 1'b0;
    w_last       = 1'b0;
    w_accept     = 1'b0;
    w_beat       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        msg_ready = 1'b1;
        if (msg_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_MSG;
        end
      end
      ST_MSG: begin
        cw_valid = 1'b1;
        cw_bit   = r_sr[K-1];
        if (cw_ready) begin
          w_beat = 1'b1;
          if (r_cnt == CW'(K - 1)) w_state_next = ST_PAR;
        end
      end
      ST_PAR: begin
        cw_valid = 1'b1;
        cw_bit   = w_rem[P-1];
        w_last   = (r_cnt == CW'(P - 1));
        if (cw_ready) begin
          w_beat = 1'b1;
          if (w_last) w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign cw_last = w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Counter restarts at every phase change so it indexes bits within MSG and within PAR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_cnt <= '0;
    else if (w_accept)                  r_cnt <= '0;
    else if (w_beat) begin
      if (w_state_next != r_state)      r_cnt <= '0;
      else                              r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_sr <= '0;
    else if (w_accept)                  r_sr <= msg;
    else if (w_beat && r_state == ST_MSG) r_sr <= r_sr << 1;
  end

  bch_lfsr_rem #(
    .P (P),
    .G (W_G)
  ) u_rem (
    .clk   (clk),
    .rst   (rst),
    .en    (w_beat),
    .clr   (w_accept),
    .din   (r_sr[K-1]),
    .fb_en (r_state == ST_MSG),
    .rem   (w_rem)
  );

`ifdef BCH_ENC_PARITY_PORT_EN
  logic         r_pvalid;
  logic [P-1:0] r_parity;

  // On the PAR entry cycle the remainder register already holds the final value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pvalid <= 1'b0;
      r_parity <= '0;
    end else begin
      r_pvalid <= (r_state == ST_MSG) && (w_state_next == ST_PAR);
      if (r_pvalid) r_parity <= w_rem;
    end
  end

  assign parity_valid = r_pvalid;
  assign parity       = r_pvalid ? w_rem : r_parity;
`endif

endmodule

// File: tb/tb_bch_enc_serial.sv
// tb/tb_bch_enc_serial.sv - directed self-checking bench for bch_enc_serial (BCH(15,7), g=0x1D1)
module tb_bch_enc_serial;

  logic       clk;
  logic       rst;
  logic [6:0] msg;
  logic       msg_valid;
  logic       msg_ready;
  logic       cw_bit;
  logic       cw_valid;
  logic       cw_ready;
  logic       cw_last;
`ifdef BCH_ENC_PARITY_PORT_EN
  logic [7:0] parity;
  logic       parity_valid;
`endif

  int n_checks = 0;
  int n_errors = 0;

  bch_enc_serial dut (
    .clk          (clk),
    .rst          (rst),
    .msg          (msg),
    .msg_valid    (msg_valid),
    .msg_ready    (msg_ready),
    .cw_bit       (cw_bit),
    .cw_valid     (cw_valid),
    .cw_ready     (cw_ready),
    .cw_last      (cw_last)
`ifdef BCH_ENC_PARITY_PORT_EN
    ,
    .parity       (parity),
    .parity_valid (parity_valid)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sends one word and collects its codeword; rnd randomises cw_ready and injects stray msg_valid pulses.
  task automatic run_word(input logic [6:0] m, input logic [14:0] exp_cw, input bit rnd, input string tag);
    logic [14:0] cw;
    int  nbits, lastpos, lastcyc, first_cyc, unstable, busy_ready, drops, npv, pvpos;
    bit  done, prev_stall;
    logic pv_bit, pv_valid, pv_last;
    cw = '0; nbits = 0; lastpos = 0; lastcyc = 0; first_cyc = 0; unstable = 0;
    busy_ready = 0; drops = 0; npv = 0; pvpos = -1; done = 0; prev_stall = 0;
    pv_bit = 0; pv_valid = 0; pv_last = 0;
    @(negedge clk);
    chk({tag, "_ready_idle"}, 32'(msg_ready), 32'd1);
    msg = m; msg_valid = 1'b1; cw_ready = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
      @(negedge clk);
      cw_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      msg_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      msg       = 7'($urandom);
      if (msg_ready) busy_ready++;
      if (!cw_valid) drops++;
      if (prev_stall && (cw_bit !== pv_bit || cw_valid !== pv_valid || cw_last !== pv_last)) unstable++;
      if (first_cyc == 0 && cw_valid) first_cyc = cyc;
`ifdef BCH_ENC_PARITY_PORT_EN
      if (parity_valid) begin npv++; pvpos = nbits; end
`endif
      if (cw_valid && cw_ready) begin
        cw = {cw[13:0], cw_bit};
        nbits++;
        if (cw_last) begin lastpos = nbits; lastcyc = cyc; done = 1; end
      end
      prev_stall = cw_valid && !cw_ready;
      pv_bit = cw_bit; pv_valid = cw_valid; pv_last = cw_last;
    end
    @(negedge clk);
    msg_valid = 1'b0; cw_ready = 1'b1;
    chk({tag, "_done"},        32'(done),       32'd1);
    chk({tag, "_codeword"},    32'(cw),         32'(exp_cw));
    chk({tag, "_last_pos"},    32'(lastpos),    32'd15);
    chk({tag, "_first_lat"},   32'(first_cyc),  32'd1);
    chk({tag, "_stall_hold"},  32'(unstable),   32'd0);
    chk({tag, "_ready_busy"},  32'(busy_ready), 32'd0);
    chk({tag, "_valid_drop"},  32'(drops),      32'd0);
    chk({tag, "_ready_back"},  32'(msg_ready),  32'd1);
    chk({tag, "_valid_idle"},  32'(cw_valid),   32'd0);
    if (!rnd) chk({tag, "_cycles"}, 32'(lastcyc), 32'd15);
`ifdef BCH_ENC_PARITY_PORT_EN
    chk({tag, "_pv_count"},    32'(npv),        32'd1);
    chk({tag, "_pv_pos"},      32'(pvpos),      32'd7);
    chk({tag, "_parity_hold"}, 32'(parity),     32'(exp_cw[7:0]));
`endif
  endtask

  initial begin
    rst = 1'b1; msg = '0; msg_valid = 1'b0; cw_ready = 1'b0;
    #12;
    chk("rst_msg_ready", 32'(msg_ready), 32'd1);
    chk("rst_cw_valid",  32'(cw_valid),  32'd0);
    chk("rst_cw_bit",    32'(cw_bit),    32'd0);
    chk("rst_cw_last",   32'(cw_last),   32'd0);
`ifdef BCH_ENC_PARITY_PORT_EN
    chk("rst_parity",    32'(parity),    32'd0);
    chk("rst_pvalid",    32'(parity_valid), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // x^8 mod g = 0xD1; x^14 mod g = 0xE8; all-ones word gives parity 0xFF.
    run_word(7'h01, 15'h01D1, 1'b0, "m01");
    run_word(7'h40, 15'h40E8, 1'b0, "m40");
    run_word(7'h41, 15'h4139, 1'b0, "m41");
    run_word(7'h00, 15'h0000, 1'b0, "m00");
    run_word(7'h7F, 15'h7FFF, 1'b0, "m7f");
    run_word(7'h01, 15'h01D1, 1'b1, "m01_bp");
    run_word(7'h41, 15'h4139, 1'b1, "m41_bp");

    // Abort msg 0x40 while its third parity bit is on the wire.
    @(negedge clk);
    msg = 7'h40; msg_valid = 1'b1; cw_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    msg_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_pre_valid", 32'(cw_valid), 32'd1);
    chk("abort_pre_bit",   32'(cw_bit),   32'd1);
    rst = 1'b1;
    #1;
    chk("abort_cw_valid",  32'(cw_valid),  32'd0);
    chk("abort_msg_ready", 32'(msg_ready), 32'd1);
    chk("abort_cw_last",   32'(cw_last),   32'd0);
`ifdef BCH_ENC_PARITY_PORT_EN
    chk("abort_parity",    32'(parity),    32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid",  32'(cw_valid),  32'd0);
    run_word(7'h01, 15'h01D1, 1'b0, "m01_post");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
